// File: rtl/biriscv_fetch_unit.sv
// Purpose : fetch PC generation, 64-bit icache read requests, two-instruction packets to decode.
// Latency : icache response reaches decode combinationally (0 cycles); a skidded packet appears 1 cycle later.
// Backpress: one-entry skid buffer holds a packet decode refused; no new request issues while it is occupied.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   fetch_*                            packet to decode (valid/accept handshake)
//   branch_request_i/pc_i/priv_i       redirect from execute/CSR, highest priority
//   icache_rd_o/pc_o/priv_o/accept_i   read request to the instruction cache
//   icache_valid_i/inst_i/error_i/
//   icache_page_fault_i                read response from the instruction cache
module biriscv_fetch_unit #(
    parameter logic [31:0] BOOT_VECTOR = 32'h8000_0000,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    // Decode interface
    input  logic        fetch_accept_i,
    output logic        fetch_valid_o,
    output logic [63:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic [1:0]  fetch_pred_branch_o,
    output logic        fetch_fault_fetch_o,
    output logic        fetch_fault_page_o,

    // Branch interface
    input  logic        branch_request_i,
    input  logic [31:0] branch_pc_i,
    input  logic [1:0]  branch_priv_i,

    // Instruction cache interface
    output logic        icache_rd_o,
    output logic [31:0] icache_pc_o,
    output logic [1:0]  icache_priv_o,
    input  logic        icache_accept_i,
    input  logic        icache_valid_i,
    input  logic [63:0] icache_inst_i,
    input  logic        icache_error_i,
    input  logic        icache_page_fault_i
);

    // One fully formed packet as presented to decode.
    typedef struct packed {
        logic        vld;
        logic [63:0] instr;
        logic [31:0] pc;
        logic        fault_fetch;
        logic        fault_page;
    } pkt_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] pc_q;           // next PC to request
    logic [1:0]  priv_q;         // privilege used for fetches
    logic        outstanding_q;  // one request in flight
    logic [31:0] req_pc_q;       // PC of the in-flight request
    logic        discard_q;      // in-flight response belongs to a redirected-away stream
    pkt_t        skid_q;         // packet decode did not take

    // ------------------------------------------------------------------
    // Response qualification
    // ------------------------------------------------------------------
    logic resp_vld;   // response that matches a request we actually made
    logic resp_live;  // response that may reach decode this cycle
    logic req_fire;

    // A response with nothing outstanding (e.g. one that straddled a reset)
    // is not ours and must not influence anything.
    assign resp_vld  = icache_valid_i & outstanding_q;
    assign resp_live = resp_vld & ~discard_q & ~branch_request_i;

    // A new request may go out when the pipe is empty or the current response
    // leaves it this cycle (taken by decode or dropped as stale). While a packet
    // sits in the skid buffer nothing is requested, so at most one response can
    // ever be waiting for decode. Held low during reset so every control output
    // is quiet until reset is released.
    assign icache_rd_o = rst_ni
                       & ~branch_request_i
                       & ~skid_q.vld
                       & (~outstanding_q | resp_vld)
                       & (~resp_vld | fetch_accept_i | discard_q);

    assign req_fire      = icache_rd_o & icache_accept_i;
    assign icache_pc_o   = {pc_q[31:3], 3'b000};
    assign icache_priv_o = priv_q;

    // ------------------------------------------------------------------
    // Packet formation
    // ------------------------------------------------------------------
    // A packet entered at the upper word of a 64-bit line has no valid slot 0;
    // a NOP fills it so decode always sees a pair.
    pkt_t resp_pkt;
    pkt_t out_pkt;

    always_comb begin
        resp_pkt             = '0;
        resp_pkt.vld         = resp_live;
        resp_pkt.pc          = req_pc_q;
        resp_pkt.fault_fetch = icache_error_i;
        resp_pkt.fault_page  = icache_page_fault_i;
        if (req_pc_q[2]) begin
            resp_pkt.instr = {icache_inst_i[63:32], NOP_INSTR};
        end else begin
            resp_pkt.instr = icache_inst_i;
        end
    end

    // Skid buffer has priority: it always holds the older packet.
    always_comb begin
        out_pkt = '0;
        if (!branch_request_i) begin
            if (skid_q.vld) begin
                out_pkt = skid_q;
            end else if (resp_live) begin
                out_pkt = resp_pkt;
            end
        end
    end

    assign fetch_valid_o       = out_pkt.vld;
    assign fetch_instr_o       = out_pkt.instr;
    assign fetch_pc_o          = out_pkt.pc;
    assign fetch_fault_fetch_o = out_pkt.fault_fetch;
    assign fetch_fault_page_o  = out_pkt.fault_page;
    assign fetch_pred_branch_o = 2'b00;

    // ------------------------------------------------------------------
    // PC and privilege
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q   <= BOOT_VECTOR;
            priv_q <= 2'b11;
        end else if (branch_request_i) begin
            pc_q   <= branch_pc_i & ~32'd3;
            priv_q <= branch_priv_i;
        end else if (req_fire) begin
            // Sequential fetch always continues at the next 64-bit line.
            pc_q <= {pc_q[31:3] + 29'd1, 3'b000};
        end
    end

    // ------------------------------------------------------------------
    // In-flight request tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= 1'b0;
            req_pc_q      <= 32'd0;
        end else if (req_fire) begin
            // Covers the response-and-new-accept cycle: stays outstanding.
            outstanding_q <= 1'b1;
            req_pc_q      <= pc_q;
        end else if (resp_vld) begin
            outstanding_q <= 1'b0;
        end
    end

    // A redirect while a request is still in flight marks its response stale.
    // If that response lands in the redirect cycle itself it is dropped there
    // and nothing needs remembering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            discard_q <= 1'b0;
        end else if (branch_request_i) begin
            discard_q <= outstanding_q & ~icache_valid_i;
        end else if (resp_vld && discard_q) begin
            discard_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            skid_q <= '0;
        end else if (branch_request_i) begin
            skid_q <= '0;
        end else if (skid_q.vld) begin
            if (fetch_accept_i) begin
                skid_q <= '0;
            end
        end else if (resp_live && !fetch_accept_i) begin
            skid_q <= resp_pkt;
        end
    end

endmodule
